axis_adc_avg_decim: RTL
=======================

Name: axis_adc_avg_decim

Overview:
- Downstream of the SPI ADC capture stage: consumes its 32-bit AXI-Stream conversion words and produces boxcar-averaged, decimated words.
- Each input word is `{sample[23:0] signed, status[7:0]}`.
- Averages 2^R consecutive samples, where R is a run-time log2 ratio. The output has the same format, which keeps the DMA/packer further downstream format-agnostic.

Parameters:
- MAX_LOG2_RATIO, 8, largest supported R. The accumulator is 24+MAX_LOG2_RATIO bits.
- FRAME_LEN, 1024, output words per tlast frame. Used only with the optional feature; must be ≥1.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- log2_ratio  in  4  requested R; values above MAX_LOG2_RATIO clamp to MAX_LOG2_RATIO
- s_axis_tdata  in  32  conversion word: [31:8] signed sample, [7:0] status
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  32  averaged word: [31:8] signed mean, [7:0] OR of block status bytes
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready

Behaviour:
- Clock and reset: single clock aclk. aresetn is asynchronous, active-low.
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0.
  - Accumulator, status OR and sample counter all 0.
  - Latched ratio R_act=0.
  - s_axis_tready follows its combinational equation from the reset state, i.e. 1.
- Ratio latching: R_act is loaded from clamp(log2_ratio) when the first sample of a block is accepted (counter==0). Changes to log2_ratio mid-block take effect at the next block.
- Block states, implemented as FSM IDLE/ACCUM tracked by the counter:
  - IDLE (counter==0): the next accepted sample starts a block.
  - ACCUM: counter runs 1..2^R_act−1.
  - LAST: the accepted sample is the final one when counter==2^R_act−1 (counter 0 when R_act=0).
- Transfer: a transfer occurs on s_axis_tvalid & s_axis_tready.
  - Sign-extend the sample and add it to the accumulator.
  - OR the status byte into the status register.
  - The first sample of a block replaces the accumulator and status register rather than adding.
- Ready rule:
  - s_axis_tready=1 for non-final samples.
  - For the final sample, s_axis_tready = ~m_axis_tvalid | m_axis_tready.
  - This is combinational from registers and m_axis_tready only, never from s_axis_tvalid.
- Output load: on a final-sample transfer, at the next edge:
  - m_axis_tdata[31:8] = (acc_final >>> R_act)[23:0]. This is an arithmetic shift, floor rounding toward −∞.
  - m_axis_tdata[7:0] = status OR including the final sample.
  - m_axis_tvalid=1, and the counter returns to 0.
- Latency: one cycle from the final-sample transfer to m_axis_tvalid.
- Throughput: one sample per cycle. The output is held stable while tvalid & ~tready.
- Simultaneous events: output drained (m_axis_tready) and a new final sample arriving in the same cycle → the new result loads with no bubble; tvalid stays 1.
- Output drain: m_axis_tvalid clears on m_axis_tready only if no new result is loaded in the same cycle.
- Arithmetic: the accumulator never overflows. The worst case is 2^MAX_LOG2_RATIO × −2^23, which fits 24+MAX_LOG2_RATIO bits signed. The mean always fits in 24 bits.
- Reset mid-block: the partial block is discarded and no output is produced.
- Backpressure: only the final sample of a block ever stalls. Upstream holds its word per AXI-S rules.

Optional Feature:
- Macro: AXIS_ADC_AVG_TLAST_EN.
- When defined:
  - Adds output port m_axis_tlast (out, 1), reset 0.
  - An output-word counter (clog2(FRAME_LEN) bits) increments on each m_axis handshake and wraps to 0 after FRAME_LEN words.
  - m_axis_tlast=1 together with the word loaded while the counter equals FRAME_LEN−1, held with that word's tdata.
  - The counter resets to 0 on aresetn and is unaffected by ratio changes.
- When undefined: no tlast port, no frame counter. The stream is unframed.

Test Plan:
- R=0, inputs 0x00000501, 0xFFFFFF02 → outputs identical words, each one cycle after acceptance. s_axis_tready is constantly 1 with m_axis_tready=1.
- R=2, samples +10,+20,+30,+41 with status 0x01,0,0,0x80 → one output: mean 25 (101>>2), m_axis_tdata=0x00001981.
- R=1, samples −3,−2 → mean floor(−2.5)=−3: m_axis_tdata[31:8]=0xFFFFFD. Also R=8 with all −8388608 → −8388608, no overflow.
- m_axis_tready=0 with R=1 and a continuous input stream → first result held stable. s_axis_tready drops only on the second block's final sample. Release → no bubble, no sample lost or duplicated.
- log2_ratio changed 2→0 on the second sample of a block → current block still averages 4 samples; next samples pass through 1:1. Also log2_ratio=15 → behaves as R=MAX_LOG2_RATIO.
- aresetn pulsed low after 2 of 4 samples → no output. The next 4 samples yield exactly one correct mean. With AXIS_ADC_AVG_TLAST_EN and FRAME_LEN=3 → tlast on output words 3, 6, 9.

Source files
------------

// File: rtl/axis_adc_avg_decim_if.sv
// AXI-Stream word bundle shared by the ADC averaging stage's input and output.
// AXIS_ADC_AVG_TLAST_EN adds the tlast frame marker.
interface axis_adc_avg_decim_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
`ifdef AXIS_ADC_AVG_TLAST_EN
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/axis_adc_avg_decim.sv
// Boxcar average of 2^R signed ADC samples, one output word per block.
// Optional AXIS_ADC_AVG_TLAST_EN frames the output with tlast every FRAME_LEN words.
module axis_adc_avg_decim #(
    parameter int MAX_LOG2_RATIO = 8,
    parameter int FRAME_LEN      = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [3:0]            log2_ratio,
    axis_adc_avg_decim_if.slave   s_axis,
    axis_adc_avg_decim_if.master  m_axis
);
    localparam int AW = 24 + MAX_LOG2_RATIO;
    localparam int CW = MAX_LOG2_RATIO;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

    if (FRAME_LEN < 1) begin : g_frame_len_invalid
        $error("FRAME_LEN must be at least 1");
    end

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [3:0]           r_act_r;
    logic signed [AW-1:0] acc_r;
    logic [7:0]           status_r;
    logic [31:0]          m_tdata_r;
    logic                 m_tvalid_r;

    logic [3:0]           r_req_s;
    logic [3:0]           r_eff_s;
    logic [CW:0]          one_shl_s;
    logic [CW-1:0]        last_cnt_s;
    logic                 first_s;
    logic                 is_last_s;
    logic                 s_ready_s;
    logic                 xfer_s;
    logic signed [AW-1:0] sample_ext_s;
    logic signed [AW-1:0] sum_s;
    logic signed [AW-1:0] shifted_s;
    logic [7:0]           status_nxt_s;

    // Block bookkeeping: the ratio in force is the live request only for a block's first sample.
    always_comb begin
        r_req_s = log2_ratio;
        if (log2_ratio > 4'(MAX_LOG2_RATIO)) begin
            r_req_s = 4'(MAX_LOG2_RATIO);
        end else begin
            r_req_s = log2_ratio;
        end
        first_s    = (state_r == ST_IDLE);
        r_eff_s    = first_s ? r_req_s : r_act_r;
        one_shl_s  = (CW + 1)'(1'b1) << r_eff_s;
        last_cnt_s = one_shl_s[CW-1:0] - CW'(1'b1);
        is_last_s  = (cnt_r == last_cnt_s);
    end

    // Only a block's final sample can stall, and only while a result is still undelivered.
    always_comb begin
        s_ready_s = 1'b1;
        if (is_last_s) begin
            s_ready_s = ~m_tvalid_r | m_axis.tready;
        end else begin
            s_ready_s = 1'b1;
        end
        xfer_s = s_axis.tvalid & s_ready_s;
    end

    // Datapath: sign-extended running sum, status OR, floor-rounded mean.
    always_comb begin
        sample_ext_s = {{MAX_LOG2_RATIO{s_axis.tdata[31]}}, s_axis.tdata[31:8]};
        sum_s        = acc_r + sample_ext_s;
        status_nxt_s = status_r | s_axis.tdata[7:0];
        if (first_s) begin
            sum_s        = sample_ext_s;
            status_nxt_s = s_axis.tdata[7:0];
        end else begin
            sum_s        = acc_r + sample_ext_s;
            status_nxt_s = status_r | s_axis.tdata[7:0];
        end
        shifted_s = sum_s >>> r_eff_s;
    end

    // Block FSM: IDLE waits for a block's first sample, ACCUM counts the rest.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            r_act_r  <= 4'd0;
            acc_r    <= '0;
            status_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        acc_r    <= sum_s;
                        status_r <= status_nxt_s;
                        r_act_r  <= r_req_s;
                        if (!is_last_s) begin
                            cnt_r   <= CW'(1'b1);
                            state_r <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (xfer_s) begin
                        acc_r    <= sum_s;
                        status_r <= status_nxt_s;
                        if (is_last_s) begin
                            cnt_r   <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r   <= cnt_r + CW'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Output register: a new result may replace a word being drained in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata_r  <= 32'h0000_0000;
            m_tvalid_r <= 1'b0;
        end else if (xfer_s && is_last_s) begin
            m_tdata_r  <= {shifted_s[23:0], status_nxt_s};
            m_tvalid_r <= 1'b1;
        end else if (m_axis.tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign s_axis.tready = s_ready_s;
    assign m_axis.tdata  = m_tdata_r;
    assign m_axis.tvalid = m_tvalid_r;

`ifdef AXIS_ADC_AVG_TLAST_EN
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [FW-1:0] fcnt_r;
    logic [FW-1:0] fcnt_nxt_s;
    logic          m_tlast_r;

    // Index of the next word to be loaded, counting this cycle's handshake.
    always_comb begin
        fcnt_nxt_s = fcnt_r;
        if (m_tvalid_r && m_axis.tready) begin
            fcnt_nxt_s = (fcnt_r == FW'(FRAME_LEN - 1)) ? '0 : fcnt_r + FW'(1'b1);
        end else begin
            fcnt_nxt_s = fcnt_r;
        end
    end

    // Frame counter and tlast travel with the word they describe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fcnt_r    <= '0;
            m_tlast_r <= 1'b0;
        end else begin
            fcnt_r <= fcnt_nxt_s;
            if (xfer_s && is_last_s) begin
                m_tlast_r <= (fcnt_nxt_s == FW'(FRAME_LEN - 1));
            end
        end
    end

    assign m_axis.tlast = m_tlast_r;
`endif
endmodule
